// File: rtl/px_freq_counter.sv
// Per-pixel ring-oscillator frequency counter: enables one oscillator, syncs it into clk and counts edges over a gate.
// Optional build macro PXCNT_AVG4_EN: four back-to-back gate windows, count reports their average.
module px_freq_counter #(
    parameter int unsigned N_PX    = 20,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GATE_W  = 16,
    parameter int unsigned ARM_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_PX-1:0]   clk_px,
    input  logic [4:0]        px_addr,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    input  logic              ack,
    output logic [N_PX-1:0]   osc_en,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              drdy,
    output logic              ovf,
    output logic              err
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ARM_W  = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
`ifdef PXCNT_AVG4_EN
    localparam int unsigned ACC_W  = CNT_W + 2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

    state_t              state, state_nx;
    logic                req_q, req_nx;
    logic                bad_q, bad_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic [GATE_W-1:0]   gate_q, gate_nx;
    logic [ARM_W-1:0]    arm_cnt, arm_nx;
    logic [GATE_W-1:0]   gate_cnt, gcnt_nx;
    logic [CNT_W-1:0]    win_cnt, win_nx;
    logic [N_PX-1:0]     osc_en_nx;
    logic                busy_nx, drdy_nx, ovf_nx, err_nx;
    logic                px_sel, sync1, sync2, hist, pulse;
    logic                addr_bad, arm_done, gate_last, gate_end, win_sat;
    logic [CNT_W-1:0]    win_inc;
`ifdef PXCNT_AVG4_EN
    logic [1:0]          win_idx, widx_nx;
    logic [ACC_W-1:0]    acc, acc_nx, acc_sum;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
`endif

    // Oscillator mux; an out-of-range latched address selects nothing
    always_comb begin
        px_sel = 1'b0;
        for (int i = 0; i < N_PX; i++) begin
            if (addr_q == ADDR_W'(i)) px_sel = clk_px[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= px_sel;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign pulse     = sync2 & ~hist;
    assign addr_bad  = 32'(px_addr) >= N_PX;
    assign arm_done  = arm_cnt == ARM_W'(ARM_CYC - 1);
    assign gate_last = gate_cnt == (gate_q - GATE_W'(1));
    assign win_sat   = pulse && (win_cnt == '1);
    assign win_inc   = (pulse && !win_sat) ? win_cnt + CNT_W'(1) : win_cnt;

`ifdef PXCNT_AVG4_EN
    assign acc_sum  = acc + ACC_W'(win_inc);
    assign gate_end = gate_last && (win_idx == 2'd3);
    assign count    = cnt_q;
`else
    assign gate_end = gate_last;
    assign count    = win_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // A start is captured one edge before the FSM acts on it
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (req_q) state_nx = bad_q ? S_DONE : S_ARM;
            S_ARM:          if (arm_done) state_nx = (gate_q == '0) ? S_DONE : S_GATE;
            S_GATE:         if (gate_end) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_nx    = req_q;
        bad_nx    = bad_q;
        addr_nx   = addr_q;
        gate_nx   = gate_q;
        arm_nx    = arm_cnt;
        gcnt_nx   = gate_cnt;
        win_nx    = win_cnt;
        osc_en_nx = osc_en;
        busy_nx   = busy;
        drdy_nx   = drdy;
        ovf_nx    = ovf;
        err_nx    = err;
`ifdef PXCNT_AVG4_EN
        widx_nx   = win_idx;
        acc_nx    = acc;
        cnt_nx    = cnt_q;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (req_q) begin
                    req_nx = 1'b0;
                    if (bad_q) begin
                        err_nx  = 1'b1;
                        drdy_nx = 1'b1;
                    end else begin
                        busy_nx   = 1'b1;
                        osc_en_nx = N_PX'(1) << addr_q;
                        arm_nx    = '0;
                    end
                end else if (start) begin
                    req_nx  = 1'b1;
                    bad_nx  = addr_bad;
                    addr_nx = px_addr;
                    gate_nx = gate_len;
                    win_nx  = '0;
                    drdy_nx = 1'b0;
                    ovf_nx  = 1'b0;
                    err_nx  = 1'b0;
`ifdef PXCNT_AVG4_EN
                    widx_nx = '0;
                    acc_nx  = '0;
                    cnt_nx  = '0;
`endif
                end else if (ack) begin
                    drdy_nx = 1'b0;
                end
            end
            S_ARM: begin
                arm_nx = arm_cnt + ARM_W'(1);
                if (arm_done) begin
                    gcnt_nx = '0;
                    if (gate_q == '0) begin
                        busy_nx   = 1'b0;
                        osc_en_nx = '0;
                        drdy_nx   = 1'b1;
                    end
                end
            end
            S_GATE: begin
                gcnt_nx = gate_cnt + GATE_W'(1);
                win_nx  = win_inc;
                if (win_sat) ovf_nx = 1'b1;
`ifdef PXCNT_AVG4_EN
                // Fold each finished window into the accumulator
                if (gate_last) begin
                    gcnt_nx = '0;
                    win_nx  = '0;
                    acc_nx  = acc_sum;
                    widx_nx = win_idx + 2'd1;
                    if (gate_end) begin
                        cnt_nx = CNT_W'(acc_sum >> 2);
                        if (acc_sum > ACC_W'({CNT_W{1'b1}})) ovf_nx = 1'b1;
                    end
                end
`endif
                if (gate_end) begin
                    busy_nx   = 1'b0;
                    osc_en_nx = '0;
                    drdy_nx   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= 1'b0;
            bad_q    <= 1'b0;
            addr_q   <= '0;
            gate_q   <= '0;
            arm_cnt  <= '0;
            gate_cnt <= '0;
            win_cnt  <= '0;
            osc_en   <= '0;
            busy     <= 1'b0;
            drdy     <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
`ifdef PXCNT_AVG4_EN
            win_idx  <= '0;
            acc      <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            req_q    <= req_nx;
            bad_q    <= bad_nx;
            addr_q   <= addr_nx;
            gate_q   <= gate_nx;
            arm_cnt  <= arm_nx;
            gate_cnt <= gcnt_nx;
            win_cnt  <= win_nx;
            osc_en   <= osc_en_nx;
            busy     <= busy_nx;
            drdy     <= drdy_nx;
            ovf      <= ovf_nx;
            err      <= err_nx;
`ifdef PXCNT_AVG4_EN
            win_idx  <= widx_nx;
            acc      <= acc_nx;
            cnt_q    <= cnt_nx;
`endif
        end
    end
endmodule

// File: tb/tb_px_freq_counter.sv
// Directed bench for px_freq_counter: vector table of measurements plus handshake, reset and saturation sequences.
module tb_px_freq_counter;
    localparam int ARM_CYC = 4;
`ifdef PXCNT_AVG4_EN
    localparam int N_WIN = 4;
`else
    localparam int N_WIN = 1;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] gate;
        int          lo;
        int          hi;
        logic        err;
        logic        ovf;
    } vec_t;

    logic        clk, rst, start, start8, ack;
    logic        px0, px3, px7, px19;
    logic [19:0] clk_px;
    logic [4:0]  px_addr;
    logic [15:0] gate_len;
    logic [19:0] osc_en, osc_en8;
    logic [15:0] count;
    logic [7:0]  count8;
    logic        busy, drdy, ovf, err, busy8, drdy8, ovf8, err8;
    int          checks = 0;
    int          failures = 0;

    assign clk_px = {px19, 11'b0, px7, 3'b0, px3, 2'b0, px0};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin px0  = 1'b0; #3; forever #10 px0  = ~px0;  end
    initial begin px3  = 1'b0; #3; forever #20 px3  = ~px3;  end
    initial begin px7  = 1'b0; #3; forever #30 px7  = ~px7;  end
    initial begin px19 = 1'b0; #3; forever #50 px19 = ~px19; end

    px_freq_counter #(.N_PX(20), .CNT_W(16), .GATE_W(16), .ARM_CYC(4)) dut (
        .clk(clk), .rst(rst), .clk_px(clk_px), .px_addr(px_addr), .gate_len(gate_len),
        .start(start), .ack(ack), .osc_en(osc_en), .count(count), .busy(busy),
        .drdy(drdy), .ovf(ovf), .err(err)
    );

    px_freq_counter #(.N_PX(20), .CNT_W(8), .GATE_W(16), .ARM_CYC(4)) dut8 (
        .clk(clk), .rst(rst), .clk_px(clk_px), .px_addr(px_addr), .gate_len(gate_len),
        .start(start8), .ack(ack), .osc_en(osc_en8), .count(count8), .busy(busy8),
        .drdy(drdy8), .ovf(ovf8), .err(err8)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_start(input logic [4:0] a, input logic [15:0] g, input logic with_ack);
        @(negedge clk);
        px_addr = a;
        gate_len = g;
        start = 1'b1;
        ack = with_ack;
        @(posedge clk);
        #1;
        start = 1'b0;
        ack = 1'b0;
    endtask

    task automatic wait_drdy(inout int n);
        while (!drdy && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Edges from the start-sampling edge to drdy, with osc_en/busy sampled after edge 2
    task automatic run_meas(input logic [4:0] a, input logic [15:0] g,
                            output int lat, output logic [19:0] om, output logic bm);
        pulse_start(a, g, 1'b0);
        lat = 0;
        om = '0;
        bm = 1'b0;
        while (!drdy && lat < 6000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 2) begin
                om = osc_en;
                bm = busy;
            end
        end
    endtask

    initial begin
        vec_t        vecs [8];
        int          lat, n, exp_lat;
        logic [19:0] om, exp_oh;
        logic        bm, bad;

        rst = 1'b0; start = 1'b0; start8 = 1'b0; ack = 1'b0; px_addr = '0; gate_len = '0;
        vecs[0] = '{5'd3,  16'd100, 24, 26, 1'b0, 1'b0};
        vecs[1] = '{5'd7,  16'd60,  9,  11, 1'b0, 1'b0};
        vecs[2] = '{5'd19, 16'd50,  4,  6,  1'b0, 1'b0};
        vecs[3] = '{5'd0,  16'd40,  19, 21, 1'b0, 1'b0};
        vecs[4] = '{5'd20, 16'd10,  0,  0,  1'b1, 1'b0};
        vecs[5] = '{5'd3,  16'd0,   0,  0,  1'b0, 1'b0};
        vecs[6] = '{5'd31, 16'd5,   0,  0,  1'b1, 1'b0};
        vecs[7] = '{5'd5,  16'd20,  0,  0,  1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {osc_en, count, busy, drdy, ovf, err}, 0);
        chk("reset_outputs8", {osc_en8, count8, busy8, drdy8, ovf8, err8}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_meas(vecs[i].addr, vecs[i].gate, lat, om, bm);
            bad = vecs[i].addr >= 5'd20;
            exp_lat = bad ? 1 : ARM_CYC + N_WIN * int'(vecs[i].gate) + 1;
            exp_oh = bad ? 20'd0 : (20'd1 << vecs[i].addr);
            chk($sformatf("v%0d_latency", i), lat, exp_lat);
            chk_rng($sformatf("v%0d_count", i), count, vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_err", i), err, vecs[i].err);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("v%0d_osc_en_mid", i), om, exp_oh);
            chk($sformatf("v%0d_busy_mid", i), bm, !bad);
            chk($sformatf("v%0d_idle_after", i), {osc_en, busy}, 0);
        end

        // ack in DONE clears drdy only
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        chk("ack_drdy", drdy, 0);
        chk("ack_count_held", count, 0);
        run_meas(5'd3, 16'd100, lat, om, bm);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        chk("ack2_drdy", drdy, 0);
        chk_rng("ack2_count_held", count, 24, 26);

        // start during GATE is ignored
        pulse_start(5'd3, 16'd100, 1'b0);
        n = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        start = 1'b1;
        px_addr = 5'd7;
        gate_len = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        n++;
        chk("busy_start_osc_en", osc_en, 20'h00008);
        chk("busy_start_busy", busy, 1);
        wait_drdy(n);
        chk("busy_start_latency", n, ARM_CYC + N_WIN * 100 + 1);
        chk_rng("busy_start_count", count, 24, 26);

        // start + ack together in DONE begins a new measurement
        pulse_start(5'd19, 16'd50, 1'b1);
        chk("start_ack_drdy", drdy, 0);
        @(posedge clk);
        #1;
        chk("start_ack_busy", busy, 1);
        n = 1;
        wait_drdy(n);
        chk("start_ack_latency", n, ARM_CYC + N_WIN * 50 + 1);
        chk_rng("start_ack_count", count, 4, 6);

        // asynchronous reset mid-GATE
        pulse_start(5'd3, 16'd100, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {osc_en, count, busy, drdy, ovf, err}, 0);
        @(negedge clk);
        rst = 1'b1;
        run_meas(5'd3, 16'd100, lat, om, bm);
        chk("post_rst_latency", lat, ARM_CYC + N_WIN * 100 + 1);
        chk_rng("post_rst_count", count, 24, 26);

        // 8-bit counter saturates on a fast oscillator
        @(negedge clk);
        px_addr = 5'd0;
        gate_len = 16'd1000;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n = 0;
        while (!drdy8 && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sat_latency", n, ARM_CYC + N_WIN * 1000 + 1);
        chk("sat_count", count8, 255);
        chk("sat_ovf", ovf8, 1);
        chk("sat_err", err8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
